// File: rtl/data_bus_interconnect.sv
// data_bus_interconnect: single-master, eight-slave data-bus router with local error termination
module data_bus_interconnect #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             core_req,
    input  logic             core_we,
    input  logic [3:0]       core_be,
    input  logic [31:0]      core_addr,
    input  logic [31:0]      core_wdata,
    output logic             core_gnt,
    output logic             core_rvalid,
    output logic [31:0]      core_rdata,
    output logic             core_err,
    output logic [7:0]       slv_req,
    output logic             slv_we,
    output logic [3:0]       slv_be,
    output logic [31:0]      slv_addr,
    output logic [31:0]      slv_wdata,
    input  logic [7:0]       slv_gnt,
    input  logic [7:0]       slv_rvalid,
    input  logic [7:0][31:0] slv_rdata
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT_RESP, ERR_RESP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit;
    logic [2:0]    idx;

    assign slv_we    = core_we;
    assign slv_be    = core_be;
    assign slv_addr  = core_addr;
    assign slv_wdata = core_wdata;

    // Memory-map decode on the full 32-bit address
    always_comb begin
        hit = 1'b1;
        idx = 3'd0;
        if (core_addr[31:12] == 20'h00000)      idx = 3'd0;
        else if (core_addr[31:14] == 18'h00004) idx = 3'd1;
        else if (core_addr[31:14] == 18'h00040) idx = 3'd2;
        else if (core_addr[31:12] == 20'h01000) idx = 3'd3;
        else if (core_addr[31:12] == 20'h01001) idx = 3'd4;
        else if (core_addr[31:12] == 20'h01002) idx = 3'd5;
        else if (core_addr[31:12] == 20'h01003) idx = 3'd6;
        else if (core_addr[31:16] == 16'h0101)  idx = 3'd7;
        else                                     hit = 1'b0;
    end

    // Next state, request routing and response muxing; request path is held off while in reset
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        core_gnt    = 1'b0;
        core_rvalid = 1'b0;
        core_err    = 1'b0;
        core_rdata  = '0;
        slv_req     = '0;
        case (state_q)
            IDLE: begin
                if (core_req && rst_n) begin
                    if (hit) begin
                        slv_req[idx] = 1'b1;
                        core_gnt     = slv_gnt[idx];
                        if (slv_gnt[idx]) begin
                            sel_d   = idx;
                            cnt_d   = '0;
                            state_d = WAIT_RESP;
                        end
                    end else begin
                        core_gnt = 1'b1;
                        state_d  = ERR_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (slv_rvalid[sel_q]) begin
                    core_rvalid = 1'b1;
                    core_rdata  = slv_rdata[sel_q];
                    state_d     = IDLE;
                end else if (cnt_q >= CNT_LIM) begin
                    core_rvalid = 1'b1;
                    core_err    = 1'b1;
                    state_d     = IDLE;
                end
            end
            ERR_RESP: begin
                core_rvalid = 1'b1;
                core_err    = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, selected slave and timeout counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_data_bus_interconnect.sv
// tb_data_bus_interconnect: directed and randomized checks of the data-bus router against a behavioural model
module tb_data_bus_interconnect;
    localparam int TO = 4;
    localparam logic [31:0] BASE [8] = '{32'h0000_0000, 32'h0001_0000, 32'h0010_0000, 32'h0100_0000,
                                         32'h0100_1000, 32'h0100_2000, 32'h0100_3000, 32'h0101_0000};
    localparam logic [31:0] SIZE [8] = '{32'h1000, 32'h4000, 32'h4000, 32'h1000,
                                         32'h1000, 32'h1000, 32'h1000, 32'h10000};

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             core_req = 1'b0;
    logic             core_we = 1'b0;
    logic [3:0]       core_be = 4'h0;
    logic [31:0]      core_addr = 32'h0;
    logic [31:0]      core_wdata = 32'h0;
    logic             core_gnt, core_rvalid, core_err;
    logic [31:0]      core_rdata;
    logic [7:0]       slv_req;
    logic             slv_we;
    logic [3:0]       slv_be;
    logic [31:0]      slv_addr, slv_wdata;
    logic [7:0]       slv_gnt, slv_rvalid;
    logic [7:0][31:0] slv_rdata = '0;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          wcnt [8] = '{default: 0};
    int          rcnt [8] = '{default: 0};
    int          gdly [8] = '{default: 0};
    int          rdly [8] = '{default: 1};
    logic [31:0] rdat [8] = '{default: 32'h0};
    logic [7:0]  sreq = '0, sgnt = '0, force_rv = '0, noise_rv = '0;
    bit          rand_rd = 1'b0;
    bit          noise_en = 1'b0;

    data_bus_interconnect #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_be(core_be),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .slv_req(slv_req), .slv_we(slv_we), .slv_be(slv_be), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_gnt(slv_gnt), .slv_rvalid(slv_rvalid), .slv_rdata(slv_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 8; i++)
            if (a >= BASE[i] && (a - BASE[i]) < SIZE[i]) return i;
        return -1;
    endfunction

    // Slave models: grant after gdly cycles of request, respond rdly cycles after grant (0 = never)
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            slv_gnt[i]    = slv_req[i] && (wcnt[i] >= gdly[i]);
            slv_rvalid[i] = (rcnt[i] == 1) || force_rv[i] || noise_rv[i];
        end
    end
    always @(negedge clk) begin
        sreq <= slv_req;
        sgnt <= slv_gnt;
    end
    always @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            wcnt[i]      <= (sreq[i] && !sgnt[i]) ? wcnt[i] + 1 : 0;
            rcnt[i]      <= (sreq[i] && sgnt[i]) ? rdly[i] : ((rcnt[i] > 0) ? rcnt[i] - 1 : 0);
            slv_rdata[i] <= rand_rd ? $urandom : rdat[i];
        end
        noise_rv <= (noise_en && $urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
    end

    // Reference model: one outstanding transaction tracked by slave and grant cycle number
    bit          m_busy = 1'b0;
    int          m_slave = 0, m_gcyc = 0, s;
    logic [7:0]  e_req;
    logic        e_gnt, e_rv, e_err;
    logic [31:0] e_rd;
    always @(negedge clk) begin
        s = decode(core_addr);
        e_req = '0; e_gnt = 1'b0; e_rv = 1'b0; e_err = 1'b0; e_rd = '0;
        if (!rst_n) m_busy = 1'b0;
        else if (!m_busy) begin
            if (core_req && s >= 0) begin
                e_req[s] = 1'b1;
                e_gnt = slv_gnt[s];
            end else if (core_req) e_gnt = 1'b1;
        end else if (m_slave < 0) begin
            e_rv = 1'b1; e_err = 1'b1;
        end else if (slv_rvalid[m_slave]) begin
            e_rv = 1'b1; e_rd = slv_rdata[m_slave];
        end else if (cyc - m_gcyc >= TO) begin
            e_rv = 1'b1; e_err = 1'b1;
        end
        chk("m_gnt", 32'(core_gnt), 32'(e_gnt));
        chk("m_req", 32'(slv_req), 32'(e_req));
        chk("m_rvalid", 32'(core_rvalid), 32'(e_rv));
        chk("m_err", 32'(core_err & core_rvalid), 32'(e_err));
        chk("m_rdata", core_rdata, e_rd);
        chk("m_bc_addr", slv_addr, core_addr);
        chk("m_bc_wdata", slv_wdata, core_wdata);
        chk("m_bc_ctl", {27'b0, slv_we, slv_be}, {27'b0, core_we, core_be});
        if (rst_n && !m_busy && e_gnt) begin
            m_busy = 1'b1; m_slave = s; m_gcyc = cyc;
        end else if (e_rv) m_busy = 1'b0;
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a request and hold it until granted; returns grant cycle, slv_req seen and wait cycles
    task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                         output int gc, output logic [7:0] rq, output int waits);
        logic g = 1'b0;
        int n = 0;
        core_req = 1'b1; core_addr = a; core_we = w; core_be = b; core_wdata = d;
        gc = 0; rq = '0;
        while (!g && n < 64) begin
            @(negedge clk);
            g = core_gnt; rq = slv_req; gc = cyc; n++;
            @(posedge clk);
            #1;
        end
        waits = n - 1;
        if (!g) chk("gnt_bound", 32'(g), 32'd1);
        core_req = 1'b0;
    endtask

    int gc, w, first, last, r;
    logic [7:0] rq;
    logic [31:0] a;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(core_gnt), 32'd0);
        chk("rst_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_req", 32'(slv_req), 32'd0);
        chk("rst_rdata", core_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rdat[5] = 32'hDEAD_BEEF; gdly[5] = 0; rdly[5] = 1;
        issue(32'h0100_2004, 1'b0, 4'hF, 32'h0, gc, rq, w);
        chk("uart_req", 32'(rq), 32'h20);
        chk("uart_wait", w, 0);
        @(negedge clk);
        chk("uart_rvalid", 32'(core_rvalid), 32'd1);
        chk("uart_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("uart_err", 32'(core_err), 32'd0);
        @(posedge clk); #1;

        issue(32'h0001_3FFC, 1'b0, 4'hF, 32'h0, gc, rq, w);
        chk("b_code_top", 32'(rq), 32'h02);
        goto(gc + 2);
        issue(32'h0001_4000, 1'b0, 4'hF, 32'h0, gc, rq, w);
        chk("b_code_over_req", 32'(rq), 32'h00);
        chk("b_code_over_wait", w, 0);
        @(negedge clk);
        chk("b_code_over_rv", 32'(core_rvalid), 32'd1);
        chk("b_code_over_err", 32'(core_err), 32'd1);
        chk("b_code_over_rd", core_rdata, 32'd0);
        @(posedge clk); #1;
        issue(32'h0101_FFFC, 1'b0, 4'hF, 32'h0, gc, rq, w);
        chk("b_pmc_top", 32'(rq), 32'h80);
        goto(gc + 2);
        issue(32'h0102_0000, 1'b0, 4'hF, 32'h0, gc, rq, w);
        chk("b_pmc_over_req", 32'(rq), 32'h00);
        @(negedge clk);
        chk("b_pmc_over_err", 32'(core_err & core_rvalid), 32'd1);
        @(posedge clk); #1;

        gdly[2] = 3; rdly[2] = 2; rdat[2] = 32'h0BAD_F00D;
        issue(32'h0010_0000, 1'b1, 4'b0011, 32'hA5A5_1234, gc, rq, w);
        chk("wr_wait", w, 3);
        chk("wr_req", 32'(rq), 32'h04);
        chk("wr_bc", {slv_we, slv_be, slv_wdata[27:0]}, {1'b1, 4'b0011, 28'h5A5_1234});
        goto(gc + 2);
        @(negedge clk);
        chk("wr_rvalid", 32'(core_rvalid), 32'd1);
        chk("wr_err", 32'(core_err), 32'd0);
        gdly[2] = 0;
        @(posedge clk); #1;

        gdly[6] = 0; rdly[6] = 0;
        issue(32'h0100_3000, 1'b0, 4'hF, 32'h0, gc, rq, w);
        for (int k = 1; k <= TO; k++) begin
            goto(gc + k);
            @(negedge clk);
            chk("to_rvalid", 32'(core_rvalid), 32'(k == TO));
        end
        chk("to_err", 32'(core_err), 32'd1);
        chk("to_rdata", core_rdata, 32'd0);
        goto(gc + TO + 2);
        force_rv[6] = 1'b1;
        @(negedge clk);
        chk("late_rv", 32'(core_rvalid), 32'd0);
        @(posedge clk); #1;
        force_rv = '0;

        rdly[6] = TO; rdat[6] = 32'hCAFE_F00D;
        issue(32'h0100_3010, 1'b0, 4'hF, 32'h0, gc, rq, w);
        goto(gc + TO);
        @(negedge clk);
        chk("tie_rvalid", 32'(core_rvalid), 32'd1);
        chk("tie_err", 32'(core_err), 32'd0);
        chk("tie_rdata", core_rdata, 32'hCAFE_F00D);
        @(posedge clk); #1;

        gdly[3] = 0; gdly[4] = 0; rdly[3] = 1; rdly[4] = 1;
        rdat[3] = 32'h3333_3333; rdat[4] = 32'h4444_4444;
        first = 0; last = 0;
        for (int k = 0; k < 10; k++) begin
            issue((k % 2 == 1) ? 32'h0100_1008 : 32'h0100_0008, 1'b0, 4'hF, 32'h0, gc, rq, w);
            if (k == 0) first = gc;
            last = gc;
        end
        chk("b2b_span", last - first, 18);
        @(negedge clk);
        chk("b2b_last_rd", core_rdata, 32'h4444_4444);
        @(posedge clk); #1;

        rdly[3] = 4; rdat[3] = 32'h1234_5678;
        issue(32'h0100_0010, 1'b0, 4'hF, 32'h0, gc, rq, w);
        force_rv[3] = 1'b1;
        #1;
        chk("prerst_rv", 32'(core_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_rvalid", 32'(core_rvalid), 32'd0);
        chk("arst_err", 32'(core_err), 32'd0);
        chk("arst_rdata", core_rdata, 32'd0);
        chk("arst_gnt_req", {23'b0, core_gnt, slv_req}, 32'd0);
        force_rv = '0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        goto(gc + 4);
        @(negedge clk);
        chk("stale_rv", 32'(core_rvalid), 32'd0);
        @(posedge clk); #1;
        rdly[3] = 1; rdat[3] = 32'h0000_0777;
        issue(32'h0100_0020, 1'b0, 4'hF, 32'h0, gc, rq, w);
        @(negedge clk);
        chk("post_rst_rv", 32'(core_rvalid), 32'd1);
        chk("post_rst_rd", core_rdata, 32'h0000_0777);
        @(posedge clk); #1;

        rand_rd = 1'b1;
        noise_en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 8);
            if (r == 8) begin
                case ($urandom_range(0, 3))
                    0: a = 32'h0000_1000;
                    1: a = 32'h0001_4000;
                    2: a = 32'h0102_0000;
                    default: a = $urandom;
                endcase
            end else begin
                a = BASE[r] + 32'($urandom_range(0, int'(SIZE[r] >> 2) - 1)) * 32'd4;
                gdly[r] = $urandom_range(0, 3);
                rdly[r] = $urandom_range(0, 6);
            end
            issue(a, 1'($urandom), 4'($urandom), $urandom, gc, rq, w);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        noise_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_bus_interconnect.md
# data_bus_interconnect

Single-master, eight-slave data-bus router between the RISC-V core's data port and the SoC memories/peripherals. It decodes each request address against the SoC memory map and forwards the request to exactly one slave. It tracks the single outstanding transaction and routes the slave's response back to the core. Unmapped addresses and unresponsive slaves are terminated locally with an error response, so the core never hangs.

## Interface
- TIMEOUT_CYCLES, 255: cycles in WAIT_RESP without a slave rvalid before the transaction is forcibly terminated with an error (legal range 1..65535).
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- core_req  input  1  core request valid
- core_we  input  1  1 = write, 0 = read
- core_be  input  4  byte enables
- core_addr  input  32  byte address
- core_wdata  input  32  write data
- core_gnt  output  1  request accepted this cycle
- core_rvalid  output  1  response valid (one cycle)
- core_rdata  output  32  read data
- core_err  output  1  response is an error; qualified by core_rvalid
- slv_req  output  [7:0]  one-hot request to slave i
- slv_we, slv_be, slv_addr, slv_wdata  output  1/4/32/32  broadcast copies of core_we/be/addr/wdata
- slv_gnt  input  [7:0]  per-slave grant
- slv_rvalid  input  [7:0]  per-slave response valid
- slv_rdata  input  [7:0][31:0]  per-slave read data

## Operation
- Slave index and decode on core_addr, full 32 bits compared:
  - 0 boot_rom: 0x0000_0000–0x0000_0FFF
  - 1 code_ram: 0x0001_0000–0x0001_3FFF
  - 2 data_ram: 0x0010_0000–0x0010_3FFF
  - 3 gpio: 0x0100_0000–0x0100_0FFF
  - 4 spi: 0x0100_1000–0x0100_1FFF
  - 5 uart: 0x0100_2000–0x0100_2FFF
  - 6 timer: 0x0100_3000–0x0100_3FFF
  - 7 pmc: 0x0101_0000–0x0101_FFFF
  - Anything else is unmapped.
- Full address is forwarded unchanged. Slaves use only their low bits.
- FSM states: IDLE, WAIT_RESP, ERR_RESP.
- IDLE, core_req, mapped slave s:
  - slv_req[s] = 1 and core_gnt = slv_gnt[s], both combinational.
  - On grant: register sel = s, clear the timeout counter, go to WAIT_RESP.
- IDLE, core_req, unmapped:
  - No slv_req asserted; core_gnt = 1 the same cycle.
  - Go to ERR_RESP.
- WAIT_RESP:
  - slv_req = 0, core_gnt = 0. The counter increments each cycle.
  - On slv_rvalid[sel]: core_rvalid = 1, core_rdata = slv_rdata[sel], core_err = 0 (combinational pass-through); go to IDLE.
  - Else, when the counter reaches TIMEOUT_CYCLES: core_rvalid = 1, core_err = 1, core_rdata = 0; go to IDLE.
- ERR_RESP: core_rvalid = 1, core_err = 1, core_rdata = 0 for one cycle; go to IDLE.
- A slv_rvalid from a slave other than sel, or any slv_rvalid in IDLE/ERR_RESP (e.g. a late response after a timeout), is ignored.
- Writes receive a response exactly like reads. core_rdata for write responses is whatever the slave drives.
- core_rdata = 0 whenever core_rvalid = 0.

## Timing
- Reset values: state IDLE, sel 0, counter 0.
  - Outputs core_gnt, core_rvalid, core_err, slv_req are all 0; core_rdata is 0.
  - slv_we, slv_be, slv_addr, slv_wdata follow the core inputs.
- Request path is combinational; response path is combinational from slv_rvalid/slv_rdata.
- Minimum latency is grant cycle N, rvalid cycle N+1 (slave responding the cycle after its grant).
- No new grant in the response cycle, so back-to-back transactions take at least 2 cycles each.
- Unmapped access: gnt at N, error rvalid at N+1.
- Timeout: granted at N, with no slave response, error rvalid at N+TIMEOUT_CYCLES. The counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates, never wraps.
- If slv_rvalid[sel] arrives in the same cycle the timeout fires, the slave response wins (core_err = 0).
- The core must hold core_req and its payload until core_gnt. The interconnect does not latch the payload.
- rst_n assertion mid-transaction returns the FSM to IDLE immediately. The pending response is dropped, and a slave response arriving after reset release is ignored.

## Test plan
- Read 0x0100_2004 with the uart slave granting at once and returning rvalid next cycle with 0xDEAD_BEEF → slv_req = 8'b0010_0000; core_rvalid 1 cycle after gnt with rdata 0xDEAD_BEEF, err = 0.
- Boundaries: 0x0001_3FFC → slave 1; 0x0001_4000 → unmapped, gnt same cycle, rvalid+err next cycle, rdata 0, no slv_req; 0x0101_FFFC → slave 7; 0x0102_0000 → err.
- Write to 0x0010_0000, be = 4'b0011, with the data_ram slave delaying gnt by 3 cycles → core_gnt low for 3 cycles then high; slv_wdata/slv_be/slv_we match the core; rvalid with err = 0.
- TIMEOUT_CYCLES = 4, timer slave grants but never responds → core_rvalid + err exactly 4 cycles after gnt. A late slv_rvalid[6] two cycles later produces no core_rvalid.
- Slave rvalid coinciding with the timeout cycle → err = 0, slave data returned. Ten back-to-back reads alternating gpio/spi → every transaction takes 2 cycles, and every response carries the correct slave's data.
- rst_n pulsed low while in WAIT_RESP → all outputs 0 asynchronously. After release, the stale slv_rvalid is ignored and a new gpio read completes normally.
